// File: rtl/sdram_pkg.sv
// Shared constants and writer FSM state type for the SDRAM full-page write feeder.
package sdram_pkg;

    localparam int unsigned PAGE_WORDS = 512;
    localparam int unsigned PAGE_IDX_W = 9;
    localparam int unsigned F_ADDR_W   = 15;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned RAM_ADDR_W = PAGE_IDX_W + 1;
    localparam int unsigned RAM_DEPTH  = 2 * PAGE_WORDS;

    typedef enum logic [1:0] {
        WIdle,
        WReq,
        WWait,
        WBurst
    } wr_state_e;

endpackage

// File: rtl/page_buffer_ram.sv
// Ping-pong page storage: 1024x16 simple dual-port RAM, address = {bank, word index},
// one write port and one registered read port.
module page_buffer_ram
    import sdram_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [RAM_ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [RAM_ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem_q [RAM_DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Only the output register is reset so the memory array still maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sdram_page_writer.sv
// Streams 16-bit words into ping-pong 512-word pages and bursts each full page to the SDRAM
// controller. Define SDRAM_PAGE_WR_STATS_EN to add pages_written_o / stall_cycles_o counters.
module sdram_page_writer
    import sdram_pkg::*;
#(
    parameter int unsigned          PAGE_WORDS = 512,
    parameter int unsigned          NUM_PAGES  = 32768,
    parameter logic [F_ADDR_W-1:0]  BASE_PAGE  = '0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [DATA_W-1:0]   din_i,
    input  logic                din_valid_i,
    output logic                din_ready_o,
    input  logic                ctrl_ready_i,
    output logic                rw_o,
    output logic                rw_en_o,
    output logic [F_ADDR_W-1:0] f_addr_o,
    output logic [DATA_W-1:0]   f2s_data_o,
    input  logic                f2s_data_valid_i,
    output logic                frame_wrap_o,
    output logic                busy_o
`ifdef SDRAM_PAGE_WR_STATS_EN
    ,
    output logic [31:0]         pages_written_o,
    output logic [31:0]         stall_cycles_o
`endif
);

    localparam logic [PAGE_IDX_W-1:0] LastIdx  = PAGE_IDX_W'(PAGE_WORDS - 1);
    localparam logic [F_ADDR_W-1:0]   LastPage = F_ADDR_W'(32'(BASE_PAGE) + NUM_PAGES - 1);

    wr_state_e             state_q, state_d;
    logic [1:0]            full_q, full_d;
    logic                  fill_bank_q, fill_bank_d;
    logic [PAGE_IDX_W-1:0] fill_idx_q, fill_idx_d;
    logic                  drain_bank_q, drain_bank_d;
    logic [PAGE_IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [F_ADDR_W-1:0]   page_q, page_d;
    logic                  rw_en_q, rw_en_d;
    logic                  frame_wrap_q, frame_wrap_d;

    logic accept;
    logic fill_done;
    logic burst_end;

    assign din_ready_o = ~rst_i & ~full_q[fill_bank_q];
    assign accept      = din_valid_i & din_ready_o;
    assign fill_done   = accept & (fill_idx_q == LastIdx);
    assign burst_end   = f2s_data_valid_i & (state_q == WBurst) & (rd_idx_q == LastIdx);

    always_comb begin
        state_d      = state_q;
        full_d       = full_q;
        fill_bank_d  = fill_bank_q;
        fill_idx_d   = fill_idx_q;
        drain_bank_d = drain_bank_q;
        rd_idx_d     = rd_idx_q;
        page_d       = page_q;
        rw_en_d      = 1'b0;
        frame_wrap_d = 1'b0;

        if (accept) begin
            fill_idx_d = fill_done ? '0 : fill_idx_q + 1'b1;
            if (fill_done) begin
                full_d[fill_bank_q] = 1'b1;
                fill_bank_d         = ~fill_bank_q;
            end
        end

        // rd_idx_d drives the RAM read address, so the word for the next valid is already
        // registered on f2s_data_o when that valid arrives.
        unique case (state_q)
            WIdle: begin
                rd_idx_d = '0;
                if (full_q[drain_bank_q]) begin
                    state_d = WReq;
                end
            end
            WReq: begin
                rd_idx_d = '0;
                if (ctrl_ready_i) begin
                    rw_en_d = 1'b1;
                    state_d = WWait;
                end
            end
            WWait: begin
                if (f2s_data_valid_i) begin
                    rd_idx_d = rd_idx_q + 1'b1;
                    state_d  = WBurst;
                end
            end
            WBurst: begin
                if (f2s_data_valid_i) begin
                    if (rd_idx_q == LastIdx) begin
                        rd_idx_d             = '0;
                        full_d[drain_bank_q] = 1'b0;
                        drain_bank_d         = ~drain_bank_q;
                        state_d              = WIdle;
                        if (page_q == LastPage) begin
                            page_d       = BASE_PAGE;
                            frame_wrap_d = 1'b1;
                        end else begin
                            page_d = page_q + 1'b1;
                        end
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = WIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= WIdle;
            full_q       <= '0;
            fill_bank_q  <= 1'b0;
            fill_idx_q   <= '0;
            drain_bank_q <= 1'b0;
            rd_idx_q     <= '0;
            page_q       <= BASE_PAGE;
            rw_en_q      <= 1'b0;
            frame_wrap_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            full_q       <= full_d;
            fill_bank_q  <= fill_bank_d;
            fill_idx_q   <= fill_idx_d;
            drain_bank_q <= drain_bank_d;
            rd_idx_q     <= rd_idx_d;
            page_q       <= page_d;
            rw_en_q      <= rw_en_d;
            frame_wrap_q <= frame_wrap_d;
        end
    end

    page_buffer_ram u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (accept),
        .waddr_i ({fill_bank_q, fill_idx_q}),
        .wdata_i (din_i),
        .raddr_i ({drain_bank_d, rd_idx_d}),
        .rdata_o (f2s_data_o)
    );

    assign rw_o         = 1'b0;
    assign rw_en_o      = rw_en_q;
    assign f_addr_o     = page_q;
    assign frame_wrap_o = frame_wrap_q;
    assign busy_o       = (|full_q) | (state_q != WIdle);

`ifdef SDRAM_PAGE_WR_STATS_EN
    logic [31:0] pages_written_q;
    logic [31:0] stall_cycles_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pages_written_q <= '0;
            stall_cycles_q  <= '0;
        end else begin
            if (burst_end) begin
                pages_written_q <= pages_written_q + 1'b1;
            end
            if (din_valid_i && !din_ready_o && !(&stall_cycles_q)) begin
                stall_cycles_q <= stall_cycles_q + 1'b1;
            end
        end
    end

    assign pages_written_o = pages_written_q;
    assign stall_cycles_o  = stall_cycles_q;
`endif

    a_valid_in_burst: assert property (@(posedge clk_i) disable iff (rst_i)
        f2s_data_valid_i |-> (state_q == WWait || state_q == WBurst));

    a_fill_not_drain: assert property (@(posedge clk_i) disable iff (rst_i)
        fill_done |-> !(state_q != WIdle && fill_bank_q == drain_bank_q));

endmodule

// File: tb/tb_sdram_page_writer.sv
// Scoreboard bench for sdram_page_writer: accepted words are queued and popped per burst strobe.
module tb_sdram_page_writer;

    localparam int NumPages = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic        ctrl_ready = 1'b1;
    logic        rw;
    logic        rw_en;
    logic [14:0] f_addr;
    logic [15:0] f2s_data;
    logic        f2s_valid = 1'b0;
    logic        frame_wrap;
    logic        busy;
`ifdef SDRAM_PAGE_WR_STATS_EN
    logic [31:0] pages_written;
    logic [31:0] stall_cycles;
`endif

    int          checks = 0;
    int          errors = 0;
    int          page_exp = 0;
    int          wrap_total = 0;
    logic [15:0] exp_q [$];

    sdram_page_writer #(
        .PAGE_WORDS (512),
        .NUM_PAGES  (NumPages),
        .BASE_PAGE  (15'd0)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .din_i            (din),
        .din_valid_i      (din_valid),
        .din_ready_o      (din_ready),
        .ctrl_ready_i     (ctrl_ready),
        .rw_o             (rw),
        .rw_en_o          (rw_en),
        .f_addr_o         (f_addr),
        .f2s_data_o       (f2s_data),
        .f2s_data_valid_i (f2s_valid),
        .frame_wrap_o     (frame_wrap),
`ifdef SDRAM_PAGE_WR_STATS_EN
        .pages_written_o  (pages_written),
        .stall_cycles_o   (stall_cycles),
`endif
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_wrap === 1'b1) wrap_total <= wrap_total + 1;
    end

    task automatic do_reset();
        rst = 1'b1;
        din_valid = 1'b0;
        f2s_valid = 1'b0;
        ctrl_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_q.delete();
        page_exp = 0;
    endtask

    // Runs from a negedge; pushes each accepted word to the scoreboard.
    task automatic feed(input int n, input logic [15:0] base, output int stalls);
        int   i = 0;
        int   guard = 0;
        logic rdy;
        stalls = 0;
        while (i < n && guard < 20000) begin
            din_valid = 1'b1;
            din = base + 16'(i);
            rdy = din_ready;
            @(posedge clk);
            if (rdy === 1'b1) begin
                exp_q.push_back(din);
                i++;
            end else begin
                stalls++;
            end
            guard++;
            @(negedge clk);
        end
        din_valid = 1'b0;
        checks++;
        if (i != n) begin
            errors++;
            $display("FAIL feed_timeout: accepted %0d words, required %0d", i, n);
        end
    endtask

    // Acts as the controller for one page; stop_at >= 0 abandons the burst at that word.
    task automatic drain_page(input bit gapped, input int stop_at);
        int          t = 0;
        int          k = 0;
        bit          ph = 1'b0;
        logic [15:0] w;
        while (rw_en !== 1'b1 && t < 10000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (rw_en !== 1'b1) begin
            errors++;
            $display("FAIL rw_en_timeout: rw_en=%b after %0d cycles, required 1", rw_en, t);
            return;
        end
        checks++;
        if (rw !== 1'b0) begin
            errors++;
            $display("FAIL rw_write: rw=%b, required 0", rw);
        end
        checks++;
        if (f_addr !== 15'(page_exp)) begin
            errors++;
            $display("FAIL f_addr: got %0d, required %0d", f_addr, page_exp);
        end
        @(negedge clk);
        checks++;
        if (rw_en !== 1'b0) begin
            errors++;
            $display("FAIL rw_en_pulse: rw_en=%b one cycle later, required 0", rw_en);
        end
        while (k < 512) begin
            if (k == stop_at) begin
                f2s_valid = 1'b0;
                return;
            end
            if (gapped && ph) begin
                f2s_valid = 1'b0;
                checks++;
                if (exp_q.size() == 0 || f2s_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL data_hold: word %0d got %h, required %h", k, f2s_data,
                             (exp_q.size() == 0) ? 16'hxxxx : exp_q[0]);
                end
            end else begin
                f2s_valid = 1'b1;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty: word %0d got %h, required none", k, f2s_data);
                end else begin
                    w = exp_q.pop_front();
                    if (f2s_data !== w) begin
                        errors++;
                        $display("FAIL burst_data: page %0d word %0d got %h, required %h",
                                 page_exp, k, f2s_data, w);
                    end
                end
                k++;
            end
            ph = ~ph;
            @(negedge clk);
        end
        f2s_valid = 1'b0;
        checks++;
        if (frame_wrap !== (page_exp == NumPages - 1)) begin
            errors++;
            $display("FAIL frame_wrap: got %b at end of page %0d, required %b", frame_wrap,
                     page_exp, (page_exp == NumPages - 1));
        end
        page_exp = (page_exp + 1) % NumPages;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        din_valid = 1'b0;
        f2s_valid = 1'b0;
        ctrl_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (din_ready !== 1'b0) begin errors++; $display("FAIL reset_din_ready: got %b, required 0", din_ready); end
        checks++;
        if (rw_en !== 1'b0) begin errors++; $display("FAIL reset_rw_en: got %b, required 0", rw_en); end
        checks++;
        if (rw !== 1'b0) begin errors++; $display("FAIL reset_rw: got %b, required 0", rw); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        checks++;
        if (frame_wrap !== 1'b0) begin errors++; $display("FAIL reset_frame_wrap: got %b, required 0", frame_wrap); end
        checks++;
        if (f2s_data !== 16'h0) begin errors++; $display("FAIL reset_f2s_data: got %h, required 0000", f2s_data); end
        checks++;
        if (f_addr !== 15'd0) begin errors++; $display("FAIL reset_f_addr: got %0d, required 0", f_addr); end
        rst = 1'b0;
        #1;
        checks++;
        if (din_ready !== 1'b1) begin errors++; $display("FAIL post_reset_din_ready: got %b, required 1", din_ready); end
        @(negedge clk);
        exp_q.delete();
        page_exp = 0;
    endtask

    task automatic test_single_page();
        int s;
        do_reset();
        feed(512, 16'h0000, s);
        checks++;
        if (s != 0) begin errors++; $display("FAIL single_stalls: got %0d, required 0", s); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_full: got %b, required 1", busy); end
        drain_page(1'b0, -1);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_done: got %b, required 0", busy); end
    endtask

    task automatic test_back_pressure();
        int s;
        int s2;
        do_reset();
        ctrl_ready = 1'b0;
        feed(1024, 16'h1000, s);
        checks++;
        if (s != 0) begin errors++; $display("FAIL bp_early_stall: got %0d, required 0", s); end
        checks++;
        if (din_ready !== 1'b0) begin errors++; $display("FAIL bp_din_ready: got %b, required 0", din_ready); end
        checks++;
        if (rw_en !== 1'b0) begin errors++; $display("FAIL bp_rw_en_held: got %b, required 0", rw_en); end
        fork
            feed(512, 16'h1400, s2);
            begin
                ctrl_ready = 1'b1;
                repeat (3) drain_page(1'b0, -1);
            end
        join
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL bp_leftover: got %0d words, required 0", exp_q.size()); end
    endtask

    task automatic test_gapped();
        int s;
        do_reset();
        feed(512, 16'h2000, s);
        drain_page(1'b1, -1);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL gap_leftover: got %0d words, required 0", exp_q.size()); end
    endtask

    task automatic test_wrap();
        int s;
        int w0;
        do_reset();
        w0 = wrap_total;
        fork
            feed(2560, 16'h5000, s);
            repeat (5) drain_page(1'b0, -1);
        join
        checks++;
        if (wrap_total - w0 != 1) begin errors++; $display("FAIL wrap_count: got %0d pulses, required 1", wrap_total - w0); end
        checks++;
        if (f_addr !== 15'd1) begin errors++; $display("FAIL wrap_next_addr: got %0d, required 1", f_addr); end
    endtask

    task automatic test_mid_burst_reset();
        int s;
        do_reset();
        feed(512, 16'h3000, s);
        drain_page(1'b0, 200);
        rst = 1'b1;
        #1;
        checks++;
        if (din_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_din_ready: got %b, required 0", din_ready); end
        @(negedge clk);
        checks++;
        if (rw_en !== 1'b0) begin errors++; $display("FAIL mid_rst_rw_en: got %b, required 0", rw_en); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b, required 0", busy); end
        rst = 1'b0;
        exp_q.delete();
        page_exp = 0;
        @(negedge clk);
        feed(512, 16'hA000, s);
        drain_page(1'b0, -1);
    endtask

`ifdef SDRAM_PAGE_WR_STATS_EN
    task automatic test_stats();
        int s;
        do_reset();
        ctrl_ready = 1'b0;
        feed(1024, 16'h7000, s);
        din_valid = 1'b1;
        repeat (10) @(negedge clk);
        din_valid = 1'b0;
        ctrl_ready = 1'b1;
        repeat (2) drain_page(1'b0, -1);
        checks++;
        if (pages_written !== 32'd2) begin errors++; $display("FAIL stats_pages: got %0d, required 2", pages_written); end
        checks++;
        if (stall_cycles !== 32'd10) begin errors++; $display("FAIL stats_stalls: got %0d, required 10", stall_cycles); end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_single_page();
        test_back_pressure();
        test_gapped();
        test_wrap();
        test_mid_burst_reset();
`ifdef SDRAM_PAGE_WR_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
